// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_load_ctrl_pkg;

  localparam int unsigned WIDTH1_DEF   = 32;
  localparam int unsigned MEM_SIZE_DEF = 1024;
  localparam int unsigned WORD_SHIFT   = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHK,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/imem_load_ctrl_port_mux.sv
// Hands the instruction-memory port to the loader or the fetch path by state;
// fetch data is forced to zero (NOP-safe) whenever the core does not own the port.
module imem_port_mux
  import imem_load_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH1 = WIDTH1_DEF
) (
  input  state_t            state,
  input  logic [WIDTH1-1:0] ld_addr,
  input  logic              ld_wr,
  input  logic [WIDTH1-1:0] ld_wdata,
  input  logic [WIDTH1-1:0] pc_addr,
  input  logic [WIDTH1-1:0] imem_rdata,
  output logic [WIDTH1-1:0] imem_addr,
  output logic              imem_wr,
  output logic [WIDTH1-1:0] imem_wdata,
  output logic [WIDTH1-1:0] pc_rdata
);

  always_comb begin
    imem_wdata = ld_wdata;
    if (state == RUN) begin
      imem_addr = pc_addr;
      imem_wr   = 1'b0;
      pc_rdata  = imem_rdata;
    end else begin
      imem_addr = ld_addr;
      imem_wr   = ld_wr;
      pc_rdata  = '0;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams a length-prefixed image into imem,
// stalls the core meanwhile, then hands the port to fetch. Optional trailer
// checksum check is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH1    = WIDTH1_DEF,
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_start,
  input  logic                      ld_valid,
  input  logic [WIDTH1-1:0]         ld_data,
  output logic                      ld_ready,
  input  logic [WIDTH1-1:0]         pc_addr,
  output logic [WIDTH1-1:0]         pc_rdata,
  output logic                      core_stall,
  output logic [WIDTH1-1:0]         imem_addr,
  output logic                      imem_wr,
  output logic [WIDTH1-1:0]         imem_wdata,
  input  logic [WIDTH1-1:0]         imem_rdata,
  output logic                      ld_done,
  output logic                      ld_err,
  output logic [$clog2(MEM_SIZE):0] word_cnt
);

  localparam int unsigned CW = $clog2(MEM_SIZE) + 1;

  state_t            state;
  logic [CW-1:0]     len;
  logic [WIDTH1-1:0] ptr;
  logic [WIDTH1-1:0] addr_r;
  logic [WIDTH1-1:0] wdata_r;
  logic              wr_r;
  logic              last_wr;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [WIDTH1-1:0] csum;
`endif

  wire accept = ld_valid && ld_ready;

  assign last_wr = (word_cnt + CW'(1)) == len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      core_stall <= 1'b1;
      ld_ready   <= 1'b0;
      wr_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
      word_cnt   <= '0;
      len        <= '0;
      ptr        <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (ld_start) begin
          state    <= HDR;
          ld_ready <= 1'b1;
        end
        HDR: if (accept) begin
          if (ld_data == '0) begin
            state      <= RUN;
            ld_done    <= 1'b1;
            core_stall <= 1'b0;
            ld_ready   <= 1'b0;
            word_cnt   <= '0;
          end else if (ld_data > WIDTH1'(MEM_SIZE)) begin
            state    <= ERR;
            ld_err   <= 1'b1;
            ld_ready <= 1'b0;
          end else begin
            state    <= LOAD;
            len      <= ld_data[CW-1:0];
            word_cnt <= '0;
            ptr      <= WIDTH1'(BASE_ADDR);
            addr_r   <= WIDTH1'(BASE_ADDR);
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        LOAD: begin
          // addr_r already holds the pointer, so the address is stable around the pulse
          if (wr_r) begin
            wr_r     <= 1'b0;
            word_cnt <= word_cnt + CW'(1);
            if (last_wr) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
              state    <= CHK;
              ld_ready <= 1'b1;
`else
              state      <= RUN;
              ld_done    <= 1'b1;
              core_stall <= 1'b0;
`endif
            end else begin
              ptr      <= ptr + WIDTH1'(4);
              addr_r   <= ptr + WIDTH1'(4);
              ld_ready <= 1'b1;
            end
          end else if (accept) begin
            wr_r     <= 1'b1;
            wdata_r  <= ld_data;
            ld_ready <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= csum ^ ld_data;
`endif
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        CHK: if (accept) begin
          ld_ready <= 1'b0;
          if (ld_data == csum) begin
            state      <= RUN;
            ld_done    <= 1'b1;
            core_stall <= 1'b0;
          end else begin
            state  <= ERR;
            ld_err <= 1'b1;
          end
        end
`endif
        RUN: if (ld_start) begin
          state      <= HDR;
          core_stall <= 1'b1;
          ld_done    <= 1'b0;
          ld_ready   <= 1'b1;
        end
        ERR: if (ld_start) begin
          state    <= HDR;
          ld_err   <= 1'b0;
          ld_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  imem_port_mux #(.WIDTH1(WIDTH1)) u_mux (
    .state      (state),
    .ld_addr    (addr_r),
    .ld_wr      (wr_r),
    .ld_wdata   (wdata_r),
    .pc_addr    (pc_addr),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .imem_wr    (imem_wr),
    .imem_wdata (imem_wdata),
    .pc_rdata   (pc_rdata)
  );

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences and owns the single port of the instruction memory (combinational read, level-sensitive write, word index = addr >> 2).
- At boot, or on request, it streams a program image into the memory from a loader interface (testbench or debug link) and holds the core stalled.
- After loading, it hands the port to the PC fetch path.
- It replaces the ad-hoc testbench drive of the memory write port.

Parameters:
- WIDTH1, 32, data/address width; matches the instruction memory.
- MEM_SIZE, 1024, instruction memory depth in words.
- BASE_ADDR, 0, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ld_start  input  1  pulse; begin a (re)load.
- ld_valid  input  1  loader word valid.
- ld_data  input  WIDTH1  loader word.
- ld_ready  output  1  controller accepts ld_data this cycle.
- pc_addr  input  WIDTH1  fetch byte address from the PC.
- pc_rdata  output  WIDTH1  fetched instruction to the core.
- core_stall  output  1  core must hold its PC and not retire instructions.
- imem_addr  output  WIDTH1  to the memory addr port.
- imem_wr  output  1  to the memory wr port.
- imem_wdata  output  WIDTH1  to the memory wdata port.
- imem_rdata  input  WIDTH1  from the memory rdata port.
- ld_done  output  1  level; a load completed successfully.
- ld_err  output  1  level; load aborted (bad length or checksum).
- word_cnt  output  $clog2(MEM_SIZE)+1  words written in the current load.

Behaviour:
Handshake and reset
- A word transfers when ld_valid && ld_ready at a rising edge.
- ld_valid may be held; ld_data must be stable while ld_valid=1 and ld_ready=0.
- Reset values: state=IDLE, core_stall=1, ld_ready=0, imem_wr=0, imem_addr=0, imem_wdata=0, ld_done=0, ld_err=0, word_cnt=0, pc_rdata=0.
- Reset mid-load abandons the load. Already-written words remain in memory; the controller returns to IDLE.

FSM states (all outputs registered except pc_rdata and imem_addr in RUN):
- IDLE: stall=1, ready=0. ld_start → HDR.
- HDR: ready=1.
  - Accepted word is length N.
  - N==0 → RUN with ld_done=1.
  - N>MEM_SIZE → ERR.
  - Otherwise store N, clear word_cnt, set write pointer=BASE_ADDR, go to LOAD.
- LOAD: ready=1 except in the cycle a write is issued, so there is at most one accepted word per two cycles.
  - Each accepted word produces, on the next cycle, a one-cycle imem_wr=1 with imem_addr=pointer and imem_wdata=word.
  - Then pointer += 4 and word_cnt += 1.
  - Write latency is one cycle after the handshake.
  - When word_cnt reaches N after the final write pulse → RUN (or CHK if the optional feature is enabled). ld_done=1 on the same edge.
- RUN: stall=0, ready=0, imem_wr=0.
  - imem_addr=pc_addr combinationally; pc_rdata=imem_rdata combinationally (zero added fetch latency).
  - ld_start → HDR; stall=1 from the next cycle, ld_done cleared.
- ERR: stall=1, ready=0, ld_err=1. Leaves only on reset or ld_start (→HDR, ld_err cleared).

Boundary conditions
- Outside RUN, pc_rdata=0 (NOP-safe) and imem_addr is driven by the controller.
- ld_start is ignored in HDR and LOAD (no restart mid-stream).
- Simultaneous ld_start and a completing write: the write completes; ld_start is ignored.
- The pointer never exceeds BASE_ADDR + 4*(MEM_SIZE-1); the length check guarantees this.
- imem_wr is never asserted in the same cycle imem_addr changes.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Enabled: after N data words, state CHK accepts one trailer word.
  - Trailer == XOR of all N data words → RUN, ld_done=1.
  - Otherwise → ERR, ld_err=1.
  - The trailer is never written to memory.
- Disabled: no CHK state; LOAD goes directly to RUN; any word after the N-th is not accepted (ld_ready=0).

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, HDR, LOAD, CHK, RUN, ERR.
  - WIDTH1 and MEM_SIZE defaults, shared with the instruction memory.
  - Word-to-byte shift constant (2).
- One natural sub-module: imem_port_mux, which selects imem_addr/imem_wr/imem_wdata between the loader and the fetch path by state and gates pc_rdata.
- FSM, counter and checksum stay in the top module.

Test Plan:
- Reset with ld_valid=1 held → core_stall=1, ld_ready=0, imem_wr=0 until ld_start; word_cnt=0.
- ld_start, stream N=3, then 0x00000013, 0x00A00613, 0x00100693 → imem_wr pulses at addr 0, 4, 8 one cycle after each handshake; then RUN. pc_addr=4 → pc_rdata=0x00A00613.
- Header N=1025 → ERR, ld_err=1, stall held. Then ld_start, N=1, word 0x13 → RUN, ld_err=0.
- Loader drops ld_valid for 5 cycles mid-stream of N=4 → no spurious imem_wr; word_cnt advances only on handshakes; final word_cnt=4.
- ld_start in RUN → stall=1 next cycle; reload N=2 overwrites words 0–1; reset asserted after the 1st word → IDLE, word 0 new, word 1 old.
- With IMEM_LOAD_CHECKSUM_EN: N=2, words 0xF0F0F0F0 and 0x0F0F0F0F, trailer 0xFFFFFFFF → RUN. Trailer 0x0 → ERR, no trailer write.
